gold_code_multi: RTL and testbench

Parametrised multi-channel Gold code generator, the successor to the single-channel GPS C/A-style generator. One shared G1 LFSR and CHANNELS independent G2 LFSRs run in lockstep; each channel's chip is the XOR of the G1 and G2 output stages. A chip-index counter and an epoch flag mark code boundaries. A channel-select mux provides one serial output for the single-pin top level.

---
 rtl/gold_code_multi.sv | 123 ++++++++++++
 tb/tb_gold_code_multi.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gold_code_multi.sv
// gold_code_multi
//   Multi-channel Gold code generator. One shared G1 Fibonacci LFSR and
//   CHANNELS independent G2 LFSRs step in lockstep. Each channel's chip is
//   the XOR of the G1 and G2 output stages (bit N-1). A chip-index counter
//   with period 2^N-1 drives an epoch flag. A channel-select mux provides a
//   single serial output.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst       asynchronous active-high reset (all LFSRs all ones, index 0)
//   i_en        advance every LFSR and the chip index by one chip
//   i_load      synchronous reload: G1 <- ones, G2[c] <- init slice, idx <- 0
//   i_g2_init   G2 initial states, channel c at [c*N +: N]
//   i_sel       channel select for o_chip_sel (out of range gives 0)
//   o_chip      current chip of each channel
//   o_chip_sel  o_chip[i_sel]
//   o_chip_idx  index of the current chip, 0 .. 2^N-2
//   o_epoch     high while o_chip_idx == 0

// Per-LFSR slice: Fibonacci register, output stage is bit N-1 and the
// feedback parity enters at bit 0.
module gold_code_lfsr #(
  parameter int            N    = 10,
  parameter logic [N-1:0]  TAPS = '1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [N-1:0] i_init,
  output logic [N-1:0] o_state
);
  logic [N-1:0] r_s;
  logic         w_fb;

  assign w_fb    = ^(r_s & TAPS);
  assign o_state = r_s;

  // load outranks en, so a simultaneous load/en pair does not advance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_s <= '1;
    else if (i_load) r_s <= i_init;
    else if (i_en)   r_s <= {r_s[N-2:0], w_fb};
  end
endmodule

module gold_code_multi #(
  parameter int               N        = 10,
  parameter logic [N-1:0]     TAPS1    = 10'b10_0000_0100,
  parameter logic [N-1:0]     TAPS2    = 10'b11_1010_0110,
  parameter int               CHANNELS = 2,
  parameter int               SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [CHANNELS*N-1:0] i_g2_init,
  input  logic [SELW-1:0]       i_sel,
  output logic [CHANNELS-1:0]   o_chip,
  output logic                  o_chip_sel,
  output logic [N-1:0]          o_chip_idx,
  output logic                  o_epoch
);
  // Last index of the period (2^N-2): all ones with the LSB cleared.
  localparam logic [N-1:0] IDX_LAST = {{(N-1){1'b1}}, 1'b0};

  logic [N-1:0]               w_g1;
  logic [CHANNELS-1:0][N-1:0] w_g2;
  logic [CHANNELS-1:0][N-1:0] w_g2_init;
  logic [CHANNELS-1:0]        w_chip;
  logic                       w_chip_sel;
  logic [N-1:0]               r_idx;

  assign w_g2_init = i_g2_init;

  // G1 always restarts from all ones, on reset and on load alike.
  gold_code_lfsr #(.N(N), .TAPS(TAPS1)) u_g1 (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (i_en),
    .i_load  (i_load),
    .i_init  ({N{1'b1}}),
    .o_state (w_g1)
  );

  // An all-zero init locks that G2 at zero; the channel then carries the
  // bare G1 sequence. That is legal and left alone.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gold_code_lfsr #(.N(N), .TAPS(TAPS2)) u_g2 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_en    (i_en),
      .i_load  (i_load),
      .i_init  (w_g2_init[c]),
      .o_state (w_g2[c])
    );
    assign w_chip[c] = w_g1[N-1] ^ w_g2[c][N-1];
  end

  // Period is fixed at 2^N-1 regardless of whether the taps are primitive.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                r_idx <= '0;
    else if (i_load)          r_idx <= '0;
    else if (i_en) begin
      if (r_idx == IDX_LAST)  r_idx <= '0;
      else                    r_idx <= r_idx + 1'b1;
    end
  end

  // Equality scan instead of a direct index: sel codes past CHANNELS-1
  // fall through to 0 without an out-of-range read.
  always_comb begin
    w_chip_sel = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (i_sel == SELW'(c)) w_chip_sel = w_chip[c];
  end

  assign o_chip     = w_chip;
  assign o_chip_sel = w_chip_sel;
  assign o_chip_idx = r_idx;
  assign o_epoch    = (r_idx == '0);
endmodule

// File: tb/tb_gold_code_multi.sv
module tb_gold_code_multi;
  localparam int N   = 10;
  localparam int CH  = 3;
  localparam int SW  = 2;
  localparam int PER = 1023;
  localparam logic [9:0] T1 = 10'b10_0000_0100;
  localparam logic [9:0] T2 = 10'b11_1010_0110;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            en = 1'b0, load = 1'b0;
  logic [CH*N-1:0] g2_init = '0;
  logic [SW-1:0]   sel = '0;
  logic [CH-1:0]   chip;
  logic            chip_sel;
  logic [N-1:0]    chip_idx;
  logic            epoch;

  gold_code_multi #(.N(N), .TAPS1(T1), .TAPS2(T2), .CHANNELS(CH), .SELW(SW)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_load(load),
    .i_g2_init(g2_init), .i_sel(sel),
    .o_chip(chip), .o_chip_sel(chip_sel), .o_chip_idx(chip_idx), .o_epoch(epoch)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;

  // Model: whole code sequences as tables, plus the count of chips since
  // the last reset/load. Output at chip k is table[k mod period].
  bit g1seq [0:PER-1];
  bit g2seq [0:CH-1][0:PER-1];
  int m_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, k=%0d)", name, act, exp, $time, m_k);
    end
  endtask

  task automatic build_g1();
    logic [9:0] s;
    s = '1;
    for (int k = 0; k < PER; k++) begin
      g1seq[k] = s[9];
      s = {s[8:0], ^(s & T1)};
    end
  endtask

  task automatic build_g2(input int c, input logic [9:0] init);
    logic [9:0] s;
    s = init;
    for (int k = 0; k < PER; k++) begin
      g2seq[c][k] = s[9];
      s = {s[8:0], ^(s & T2)};
    end
  endtask

  function automatic logic [CH-1:0] exp_chip();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = g1seq[m_k] ^ g2seq[c][m_k];
    return v;
  endfunction

  function automatic logic exp_sel(input logic [SW-1:0] s);
    logic [CH-1:0] v;
    v = exp_chip();
    if (int'(s) < CH) return v[s];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int c = 0; c < CH; c++) build_g2(c, 10'h3FF);
  endtask

  // Drive one cycle, advance the model from the sampled inputs.
  task automatic cyc(input bit e, input bit l);
    en = e; load = l;
    @(posedge clk);
    if (!rst) begin
      if (l) begin
        m_k = 0;
        for (int c = 0; c < CH; c++) build_g2(c, g2_init[c*N +: N]);
      end else if (e) begin
        m_k = (m_k + 1) % PER;
      end
    end
    #1;
    en = 1'b0; load = 1'b0;
    sel = SW'($urandom_range(0, 3));
  endtask

  // Every-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("chip", 32'(chip), 32'(exp_chip()));
      chk("chip_idx", 32'(chip_idx), 32'(m_k));
      chk("epoch", 32'(epoch), 32'(m_k == 0));
      chk("chip_sel", 32'(chip_sel), 32'(exp_sel(sel)));
    end
  end

  initial begin
    build_g1();
    model_reset();
    // Pin the model: G1 from all ones emits ten ones, then the first
    // feedback bit (stage 3 ^ stage 10 of all ones) = 0.
    chk("model_g1_head", {22'd0, g1seq[0], g1seq[1], g1seq[2], g1seq[3], g1seq[4],
        g1seq[5], g1seq[6], g1seq[7], g1seq[8], g1seq[9]}, 32'h3FF);
    chk("model_g1_10", 32'(g1seq[10]), 32'd0);

    #1 rst = 1'b1;
    #1;
    chk("rst_idx", 32'(chip_idx), 32'd0);
    chk("rst_chip", 32'(chip), 32'd0);
    chk("rst_epoch", 32'(epoch), 32'd1);
    chk("rst_sel", 32'(chip_sel), 32'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1'b1;

    // Continuous run from reset: chip[0] zero for 10 chips, epoch only at 0.
    for (int i = 0; i < 10; i++) begin
      chk("t1_chip0", 32'(chip[0]), 32'd0);
      chk("t1_epoch", 32'(epoch), 32'(i == 0));
      cyc(1, 0);
    end
    for (int i = 10; i < PER - 1; i++) cyc(1, 0);
    chk("t1_idx_last", 32'(chip_idx), 32'd1022);
    chk("t1_no_epoch", 32'(epoch), 32'd0);
    cyc(1, 0);
    chk("t1_epoch_again", 32'(epoch), 32'd1);
    chk("t1_idx_wrap", 32'(chip_idx), 32'd0);

    // Load: channel 1 zero (pure G1), channel 0 all ones.
    g2_init = {10'($urandom_range(1, 1023)), 10'h000, 10'h3FF};
    cyc(0, 1);
    for (int i = 0; i < 10; i++) begin
      chk("t2_chip1", 32'(chip[1]), 32'd1);
      chk("t2_chip0", 32'(chip[0]), 32'd0);
      cyc(1, 0);
    end
    // Run to 500 chips, then load+en together: no advance.
    for (int i = 10; i < 500; i++) cyc(1, 0);
    chk("t3_idx500", 32'(chip_idx), 32'd500);
    cyc(1, 1);
    chk("t3_idx", 32'(chip_idx), 32'd0);
    chk("t3_epoch", 32'(epoch), 32'd1);

    // Gapped enable: 1 on, 3 off, 20 pulses.
    for (int p = 0; p < 20; p++) begin
      cyc(1, 0);
      for (int g = 0; g < 3; g++) cyc(0, 0);
    end
    chk("t4_idx", 32'(chip_idx), 32'd20);

    // Async reset between edges at chip_idx 300.
    for (int i = 20; i < 300; i++) cyc(1, 0);
    chk("t5_idx300", 32'(chip_idx), 32'd300);
    en = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("t5_idx", 32'(chip_idx), 32'd0);
    chk("t5_chip", 32'(chip), 32'd0);
    chk("t5_epoch", 32'(epoch), 32'd1);
    model_reset();
    @(posedge clk); @(posedge clk);
    #1;
    chk("t5_hold", 32'(chip_idx), 32'd0);
    rst = 1'b0;
    cyc(1, 0);
    chk("t5_first_adv", 32'(chip_idx), 32'd1);

    // Sel sweep over distinct channels.
    g2_init = {10'h2A5, 10'h13C, 10'h3FF};
    cyc(0, 1);
    for (int r = 0; r < 8; r++) begin
      repeat (7) cyc(1, 0);
      for (int s = 0; s < 4; s++) begin
        sel = SW'(s);
        #1;
        chk("t6_sel", 32'(chip_sel), 32'(exp_sel(SW'(s))));
      end
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit e, l;
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 63) == 0);
      if (l) begin
        for (int c = 0; c < CH; c++)
          g2_init[c*N +: N] = ($urandom_range(0, 7) == 0) ? 10'h000 : 10'($urandom);
      end
      cyc(e, l);
    end

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
